// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK frame sequencer.
// crc8_byte is the byte-wide CRC-8 step used when QPSK_CRC8_EN is defined.
package qpsk_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, CRC} state_t;

  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam int unsigned SYMS_PER_BYTE = 4;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/qpsk_frame_ctrl_if.sv
// Request/payload handshake and symbol output bundle of the QPSK frame sequencer.
// slave = controller side, master = requester/consumer side.
interface qpsk_frame_ctrl_if;
  logic       start;
  logic [7:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sym_tick;
  logic       i_bit;
  logic       q_bit;
  logic       tx_active;
  logic       done;
  logic       underrun;

  modport master (
    output start, len, in_data, in_valid,
    input  in_ready, sym_tick, i_bit, q_bit, tx_active, done, underrun
  );

  modport slave (
    input  start, len, in_data, in_valid,
    output in_ready, sym_tick, i_bit, q_bit, tx_active, done, underrun
  );
endinterface

// File: rtl/qpsk_crc8.sv
// Combinational next-CRC for one byte (CRC-8, poly 0x07, MSB first).
// Only instantiated when QPSK_CRC8_EN is defined; the register lives in the controller.
module qpsk_crc8 (
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);
  import qpsk_pkg::*;

  always_comb crc_out = crc8_byte(crc_in, data);
endmodule

// File: rtl/qpsk_frame_ctrl.sv
// Frame sequencer: preamble, length header, payload [, CRC when QPSK_CRC8_EN] sent as
// paced I/Q dibits, MSB first, one dibit per SYM_DIV clocks.
module qpsk_frame_ctrl #(
  parameter int unsigned SYM_DIV     = 16,
  parameter int unsigned PRE_BYTES   = 4,
  parameter logic [7:0]  PRE_PATTERN = 8'hCC
) (
  input logic         clk,
  input logic         rst,
  qpsk_frame_ctrl_if.slave bus
);
  import qpsk_pkg::*;

  localparam int unsigned CW = $clog2(SYM_DIV);
  localparam int unsigned PW = $clog2(PRE_BYTES + 1);

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt;
  logic [1:0]      sym_idx;
  logic [PW-1:0]   pre_cnt;
  logic [7:0]      len_r, sent, fetched, hold, shreg, nxt_byte;
  logic            hold_full, in_ready_w;
  logic            bnd, fin, urun, take, load_byte;
  logic            sym_tick_r, i_bit_r, q_bit_r, tx_active_r, done_r, underrun_r;

  // Boundary is evaluated one cycle early so the registered tick lands on count==SYM_DIV-1.
  assign bnd        = (state != IDLE) && (cnt == CW'(SYM_DIV - 2));
  assign in_ready_w = ((state == HDR) || (state == PAY)) && (fetched != len_r) && !hold_full;
  assign load_byte  = bnd && (sym_idx == '0) && !fin && !urun;

`ifdef QPSK_CRC8_EN
  logic [7:0] crc_r, crc_nxt, crc_data;

  assign crc_data = (state == PRE) ? len_r : hold;

  qpsk_crc8 u_crc (.crc_in(crc_r), .data(crc_data), .crc_out(crc_nxt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          crc_r <= '0;
    else if (state == IDLE)                           crc_r <= '0;
    else if (load_byte && (nxt_state == HDR || take)) crc_r <= crc_nxt;
  end
`endif

  // Next byte to put on air, decided from the byte that is just finishing.
  always_comb begin
    nxt_state = state;
    nxt_byte  = '0;
    fin       = 1'b0;
    urun      = 1'b0;
    take      = 1'b0;
    case (state)
      PRE: begin
        if (pre_cnt != PW'(PRE_BYTES)) nxt_byte = PRE_PATTERN;
        else begin
          nxt_state = HDR;
          nxt_byte  = len_r;
        end
      end
      HDR, PAY: begin
        if (sent != len_r) begin
          nxt_state = PAY;
          nxt_byte  = hold;
          take      = 1'b1;
          urun      = !hold_full;
        end else begin
`ifdef QPSK_CRC8_EN
          nxt_state = CRC;
          nxt_byte  = crc_r;
`else
          fin       = 1'b1;
`endif
        end
      end
      default: fin = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sym_idx     <= '0;
      pre_cnt     <= '0;
      len_r       <= '0;
      sent        <= '0;
      fetched     <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      shreg       <= '0;
      sym_tick_r  <= 1'b0;
      i_bit_r     <= 1'b0;
      q_bit_r     <= 1'b0;
      tx_active_r <= 1'b0;
      done_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      sym_tick_r <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          state       <= PRE;
          cnt         <= '0;
          sym_idx     <= '0;
          pre_cnt     <= '0;
          len_r       <= bus.len;
          sent        <= '0;
          fetched     <= '0;
          tx_active_r <= 1'b1;
        end
      end else begin
        cnt <= (cnt == CW'(SYM_DIV - 1)) ? '0 : cnt + 1'b1;
        if (in_ready_w && bus.in_valid) begin
          hold      <= bus.in_data;
          hold_full <= 1'b1;
          fetched   <= fetched + 1'b1;
        end
        if (bnd) begin
          if (sym_idx != '0) begin
            i_bit_r    <= shreg[7];
            q_bit_r    <= shreg[6];
            shreg      <= {shreg[5:0], 2'b00};
            sym_idx    <= (sym_idx == 2'(SYMS_PER_BYTE - 1)) ? '0 : sym_idx + 2'd1;
            sym_tick_r <= 1'b1;
          end else if (fin || urun) begin
            state       <= IDLE;
            i_bit_r     <= 1'b0;
            q_bit_r     <= 1'b0;
            tx_active_r <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            done_r      <= fin;
            underrun_r  <= urun;
          end else begin
            state      <= nxt_state;
            i_bit_r    <= nxt_byte[7];
            q_bit_r    <= nxt_byte[6];
            shreg      <= {nxt_byte[5:0], 2'b00};
            sym_idx    <= 2'd1;
            sym_tick_r <= 1'b1;
            if (state == PRE && pre_cnt != PW'(PRE_BYTES)) pre_cnt <= pre_cnt + 1'b1;
            if (take) begin
              hold_full <= 1'b0;
              sent      <= sent + 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.sym_tick  = sym_tick_r;
  assign bus.i_bit     = i_bit_r;
  assign bus.q_bit     = q_bit_r;
  assign bus.tx_active = tx_active_r;
  assign bus.done      = done_r;
  assign bus.underrun  = underrun_r;

endmodule
